// File: rtl/mmio_ctrl.sv
// MMIO controller: decodes the IO region, runs the UART TX/RX handshakes and
// keeps cycle/retired-instruction counters; load data returns one cycle after re.
module mmio_ctrl #(
    parameter logic [3:0] IO_NIBBLE = 4'h8,
    parameter int         CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        inst_commit,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [31:0] io_rdata,
    output logic        io_hit
);
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CLR    = 8'h18;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic             sel, wr, rd;
    logic [7:0]       off;
    logic [0:0]       tx_state;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] cycle_cnt, inst_cnt;
    logic             cnt_clr;
    logic [31:0]      rdata_next;
    logic             unused;

    assign sel     = (addr[31:28] == IO_NIBBLE);
    assign wr      = sel & (|we);
    assign rd      = sel & re;
    assign off     = addr[7:0];
    assign cnt_clr = wr && (off == OFF_CLR);
    // Only the low offset byte decodes; the rest of the address and upper store lanes are don't-care.
    assign unused  = ^{addr[27:8], wdata[31:8]};

    // A TX write while a byte is pending is dropped; software polls status bit0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_data  <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (wr && (off == OFF_TX) && we[0]) begin
                        tx_data  <= wdata[7:0];
                        tx_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (uart_tx_data_in_ready) tx_state <= ST_IDLE;
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    assign uart_tx_data_in        = tx_data;
    assign uart_tx_data_in_valid  = (tx_state == ST_PEND);
    assign uart_rx_data_out_ready = rd && (off == OFF_RX) && uart_rx_data_out_valid;

    // Clear takes priority over the same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (inst_commit) inst_cnt <= inst_cnt + 1'b1;
        end
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (off)
                OFF_STATUS: rdata_next = {30'b0, uart_rx_data_out_valid,
                                          (tx_state == ST_IDLE) && uart_tx_data_in_ready};
                OFF_RX:     rdata_next = uart_rx_data_out_valid ? {24'b0, uart_rx_data_out} : 32'b0;
                OFF_CYC:    rdata_next = 32'(cycle_cnt);
                OFF_INST:   rdata_next = 32'(inst_cnt);
                default:    rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= '0;
            io_hit   <= 1'b0;
        end else begin
            io_rdata <= rdata_next;
            io_hit   <= sel & (re | (|we));
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: a vector table for single-cycle accesses plus
// hand sequences for TX handshake, counter clear/wrap and reset mid-transfer.
module tb_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  we;
    logic        re, inst_commit;
    logic [7:0]  tx_data, tx_data_s;
    logic        tx_valid, tx_valid_s, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, rx_ready_s;
    logic [31:0] rdata, rdata_s;
    logic        hit, hit_s;

    int total = 0;
    int bad   = 0;
    int hs, vcyc;

    always #5 clk = ~clk;

    mmio_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_commit(inst_commit),
        .uart_tx_data_in(tx_data), .uart_tx_data_in_valid(tx_valid),
        .uart_tx_data_in_ready(tx_ready),
        .uart_rx_data_out(rx_data), .uart_rx_data_out_valid(rx_valid),
        .uart_rx_data_out_ready(rx_ready),
        .io_rdata(rdata), .io_hit(hit)
    );

    // Narrow-counter instance sharing all stimulus; its counters wrap at 16.
    mmio_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_commit(inst_commit),
        .uart_tx_data_in(tx_data_s), .uart_tx_data_in_valid(tx_valid_s),
        .uart_tx_data_in_ready(tx_ready),
        .uart_rx_data_out(rx_data), .uart_rx_data_out_valid(rx_valid),
        .uart_rx_data_out_ready(rx_ready_s),
        .io_rdata(rdata_s), .io_hit(hit_s)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  w;
        logic        r;
        logic        ic;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic        e_rxr;
        logic [31:0] e_rd;
        logic        e_hit;
        logic        e_txv;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                         input logic r, input logic c);
        addr = a; wdata = wd; we = w; re = r; inst_commit = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Reset state and first counter read
        tick();
        rst = 1'b0;
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hit", {31'b0, hit}, 32'h0);
        tick();
        tick();
        drive(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("cyc_after_rst", rdata, 32'd2);
        chk("cyc_after_rst_s", rdata_s, 32'd2);
        chk("hit_after_load", {31'b0, hit}, 32'h1);

        // Five commits, read, then clear while committing
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        repeat (5) tick();
        drive(32'h8000_0014, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("inst_5", rdata, 32'd5);
        drive(32'h8000_0018, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        tick();
        drive(32'h8000_0014, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("inst_cleared", rdata, 32'd0);
        drive(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("cyc_cleared", rdata, 32'd1);

        //           a              wd             w     r     ic    rxv   rxd    txr   e_rxr e_rd    e_hit e_txv
        tbl[0]  = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h3,  1'b1, 1'b0};
        tbl[1]  = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[2]  = '{32'h8000_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 32'h5A, 1'b1, 1'b0};
        tbl[3]  = '{32'h8000_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[4]  = '{32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[5]  = '{32'h0000_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[6]  = '{32'h8000_0018, 32'h0,         4'h8, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[7]  = '{32'h8000_0014, 32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[8]  = '{32'h8000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h1,  1'b1, 1'b0};
        tbl[9]  = '{32'h8000_0014, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h1,  1'b1, 1'b0};
        tbl[10] = '{32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[11] = '{32'h8000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4,  1'b1, 1'b0};
        tbl[12] = '{32'h8000_000C, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[13] = '{32'h8000_0008, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[14] = '{32'h1000_0008, 32'h77,        4'h1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[15] = '{32'h8000_0008, 32'h6600,      4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[16] = '{32'h8ABC_DE00, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h1,  1'b1, 1'b0};

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].a, tbl[i].wd, tbl[i].w, tbl[i].r, tbl[i].ic);
            rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_ready = tbl[i].txr;
            #1;
            chk($sformatf("v%0d_rx_ready", i), {31'b0, rx_ready}, {31'b0, tbl[i].e_rxr});
            tick();
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rd);
            chk($sformatf("v%0d_hit", i), {31'b0, hit}, {31'b0, tbl[i].e_hit});
            chk($sformatf("v%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, tbl[i].e_txv});
            if (tbl[i].r && (tbl[i].a[7:0] == 8'h10 || tbl[i].a[7:0] == 8'h14))
                chk($sformatf("v%0d_rdata_s", i), rdata_s, tbl[i].e_rd & 32'hF);
        end
        rx_valid = 1'b0; rx_data = 8'h0;

        // TX: ready low 3 cycles, then high; second byte during PEND is dropped
        tx_ready = 1'b0; hs = 0; vcyc = 0;
        drive(32'h8000_0008, 32'h41, 4'h1, 1'b0, 1'b0);
        tick();
        chk("tx_valid_up", {31'b0, tx_valid}, 32'h1);
        chk("tx_data_41", {24'b0, tx_data}, 32'h41);
        for (int c = 1; c <= 7; c++) begin
            tx_ready = (c >= 4);
            case (c)
                1:       drive(32'h8000_0000, 32'h0, 4'h0, 1'b1, 1'b0);
                2:       drive(32'h8000_0008, 32'h42, 4'h1, 1'b0, 1'b0);
                default: drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
            endcase
            if (tx_valid) begin
                vcyc++;
                chk($sformatf("tx_data_c%0d", c), {24'b0, tx_data}, 32'h41);
            end
            if (tx_valid && tx_ready) hs++;
            tick();
            if (c == 1) chk("status_pend", rdata, 32'h0);
            if (c == 4) chk("tx_valid_drop", {31'b0, tx_valid}, 32'h0);
        end
        chk("tx_valid_cycles", vcyc, 32'd4);
        chk("tx_handshakes", hs, 32'd1);
        chk("tx_idle_after", {31'b0, tx_valid}, 32'h0);

        // Counter wrap on the 4-bit instance
        drive(32'h8000_0018, 32'h0, 4'h1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (16) tick();
        drive(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("cyc_16", rdata, 32'd16);
        chk("cyc_wrap_s", rdata_s, 32'd0);
        tick();
        chk("cyc_17", rdata, 32'd17);
        chk("cyc_wrap_s1", rdata_s, 32'd1);

        // Reset in the middle of a pending TX
        tx_ready = 1'b0;
        drive(32'h8000_0008, 32'h55, 4'h1, 1'b0, 1'b0);
        tick();
        chk("tx_pend_55", {31'b0, tx_valid}, 32'h1);
        rst = 1'b1;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rst_abort_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_abort_data", {24'b0, tx_data}, 32'h0);
        drive(32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("cyc_after_rst2", rdata, 32'd0);
        tick();
        chk("cyc_after_rst2b", rdata, 32'd1);
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tx_ready = 1'b1;
        tick();
        chk("tx_stays_idle", {31'b0, tx_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
